// File: rtl/dma_desc_sched.sv
// Descriptor FIFO plus single-outstanding issue FSM feeding a DMA engine over a start/done level handshake.
// Optional REQ watchdog is built only when DMA_SCHED_TIMEOUT_EN is defined.
module dma_desc_sched #(
  parameter int DEPTH          = 4,
  parameter int AW             = 32,
  parameter int LW             = 16,
  parameter int TW             = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_src,
  input  logic [AW-1:0]              in_dst,
  input  logic [LW-1:0]              in_len,
  input  logic [TW-1:0]              in_tag,
  output logic                       eng_start,
  output logic [AW-1:0]              eng_src,
  output logic [AW-1:0]              eng_dst,
  output logic [LW-1:0]              eng_len,
  input  logic                       eng_done,
  output logic                       cmpl_valid,
  output logic [TW-1:0]              cmpl_tag,
  output logic                       cmpl_err,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = 2*AW + LW + TW;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          in_ready_reg;
  logic          push, pop;

  state_t        state_reg, state_next;
  logic          eng_start_reg, eng_start_next;
  logic [AW-1:0] eng_src_reg, eng_src_next;
  logic [AW-1:0] eng_dst_reg, eng_dst_next;
  logic [LW-1:0] eng_len_reg, eng_len_next;
  logic [TW-1:0] tag_reg, tag_next;
  logic          cmpl_valid_reg, cmpl_valid_next;
  logic [TW-1:0] cmpl_tag_reg, cmpl_tag_next;
  logic          cmpl_err_reg, cmpl_err_next;
  logic          busy_reg;

  logic [AW-1:0] head_src, head_dst;
  logic [LW-1:0] head_len;
  logic [TW-1:0] head_tag;

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES+1);
  logic [TOW-1:0] to_cnt_reg, to_cnt_next;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  assign push = in_valid && in_ready_reg;
  assign {head_src, head_dst, head_len, head_tag} = mem[rd_ptr_reg];

  // Storage carries no reset; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_src, in_dst, in_len, in_tag};
    end
  end

  always_comb begin
    state_next      = state_reg;
    eng_start_next  = eng_start_reg;
    eng_src_next    = eng_src_reg;
    eng_dst_next    = eng_dst_reg;
    eng_len_next    = eng_len_reg;
    tag_next        = tag_reg;
    cmpl_valid_next = 1'b0;
    cmpl_tag_next   = cmpl_tag_reg;
    cmpl_err_next   = cmpl_err_reg;
    pop             = 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
    to_cnt_next     = to_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop          = 1'b1;
          eng_src_next = head_src;
          eng_dst_next = head_dst;
          eng_len_next = head_len;
          tag_next     = head_tag;
          // Zero-length work never reaches the engine; it retires with an error flag.
          if (head_len == '0) begin
            cmpl_valid_next = 1'b1;
            cmpl_tag_next   = head_tag;
            cmpl_err_next   = 1'b1;
          end else begin
            eng_start_next = 1'b1;
            state_next     = REQ;
`ifdef DMA_SCHED_TIMEOUT_EN
            to_cnt_next    = '0;
`endif
          end
        end
      end
      REQ: begin
        if (eng_done) begin
          eng_start_next  = 1'b0;
          cmpl_valid_next = 1'b1;
          cmpl_tag_next   = tag_reg;
          cmpl_err_next   = 1'b0;
          state_next      = REL;
        end
`ifdef DMA_SCHED_TIMEOUT_EN
        else if (to_cnt_reg == TOW'(TIMEOUT_CYCLES-1)) begin
          eng_start_next  = 1'b0;
          cmpl_valid_next = 1'b1;
          cmpl_tag_next   = tag_reg;
          cmpl_err_next   = 1'b1;
          state_next      = REL;
        end else begin
          to_cnt_next = to_cnt_reg + TOW'(1);
        end
`endif
      end
      REL: begin
        if (!eng_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      in_ready_reg   <= 1'b1;
      eng_start_reg  <= 1'b0;
      eng_src_reg    <= '0;
      eng_dst_reg    <= '0;
      eng_len_reg    <= '0;
      tag_reg        <= '0;
      cmpl_valid_reg <= 1'b0;
      cmpl_tag_reg   <= '0;
      cmpl_err_reg   <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef DMA_SCHED_TIMEOUT_EN
      to_cnt_reg     <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg      <= count_next;
      // A pop from a full FIFO only frees the slot for the following cycle.
      in_ready_reg   <= (count_next != CW'(DEPTH));
      eng_start_reg  <= eng_start_next;
      eng_src_reg    <= eng_src_next;
      eng_dst_reg    <= eng_dst_next;
      eng_len_reg    <= eng_len_next;
      tag_reg        <= tag_next;
      cmpl_valid_reg <= cmpl_valid_next;
      cmpl_tag_reg   <= cmpl_tag_next;
      cmpl_err_reg   <= cmpl_err_next;
      busy_reg       <= (state_next != IDLE) || (count_next != '0);
`ifdef DMA_SCHED_TIMEOUT_EN
      to_cnt_reg     <= to_cnt_next;
`endif
    end
  end

  assign in_ready   = in_ready_reg;
  assign eng_start  = eng_start_reg;
  assign eng_src    = eng_src_reg;
  assign eng_dst    = eng_dst_reg;
  assign eng_len    = eng_len_reg;
  assign cmpl_valid = cmpl_valid_reg;
  assign cmpl_tag   = cmpl_tag_reg;
  assign cmpl_err   = cmpl_err_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: vector table for single descriptors plus hand sequences
// for backpressure, reset, simultaneous push/pop and (with DMA_SCHED_TIMEOUT_EN) the watchdog.
module tb_dma_desc_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_src, in_dst;
  logic [15:0] in_len;
  logic [3:0]  in_tag;
  logic        eng_start;
  logic [31:0] eng_src, eng_dst;
  logic [15:0] eng_len;
  logic        eng_done;
  logic        cmpl_valid;
  logic [3:0]  cmpl_tag;
  logic        cmpl_err;
  logic        busy;
  logic [2:0]  fifo_count;

  dma_desc_sched #(.DEPTH(4), .AW(32), .LW(16), .TW(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_dst(in_dst), .in_len(in_len), .in_tag(in_tag),
    .eng_start(eng_start), .eng_src(eng_src), .eng_dst(eng_dst), .eng_len(eng_len),
    .eng_done(eng_done),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_err(cmpl_err),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Engine model: raises done once start has been seen high for more than eng_lat negedges.
  int   eng_lat   = 0;
  bit   eng_stall = 1'b0;
  int   eng_cnt   = 0;
  initial eng_done = 1'b0;
  always @(negedge clk) begin
    if (!eng_start) begin
      eng_done = 1'b0;
      eng_cnt  = 0;
    end else if (!eng_stall) begin
      eng_cnt++;
      if (eng_cnt > eng_lat) eng_done = 1'b1;
    end
  end

  // Monitor: start-high cycles, held engine fields, completion log.
  int          mon_start_cyc = 0;
  int          mon_cmpl      = 0;
  int          mon_unstable  = 0;
  logic        prev_start    = 1'b0;
  logic [31:0] cap_src, cap_dst;
  logic [15:0] cap_len;
  logic [4:0]  cmpl_q [$];
  always @(negedge clk) begin
    if (eng_start) begin
      mon_start_cyc++;
      if (prev_start && (eng_src != cap_src || eng_dst != cap_dst || eng_len != cap_len))
        mon_unstable++;
      cap_src = eng_src;
      cap_dst = eng_dst;
      cap_len = eng_len;
    end
    prev_start = eng_start;
    if (cmpl_valid) begin
      mon_cmpl++;
      cmpl_q.push_back({cmpl_err, cmpl_tag});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Called at a negedge; the offset keeps it clear of the monitor's negedge updates.
  task automatic clear_mon();
    #1;
    mon_start_cyc = 0;
    mon_cmpl      = 0;
    mon_unstable  = 0;
    cmpl_q.delete();
  endtask

  // Offer one descriptor; returns at the negedge after it was accepted.
  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                      input logic [3:0] t);
    bit acc = 1'b0;
    in_src = s; in_dst = d; in_len = l; in_tag = t;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!acc) begin
      chk("push_accept_timeout", 64'(acc), 64'(1));
    end
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy && !eng_start && !eng_done) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) chk("wait_idle_timeout", 64'(idle), 64'(1));
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_in_ready"},   64'(in_ready),   64'(1));
    chk({tagname, "_eng_start"},  64'(eng_start),  64'(0));
    chk({tagname, "_eng_src"},    64'(eng_src),    64'(0));
    chk({tagname, "_eng_dst"},    64'(eng_dst),    64'(0));
    chk({tagname, "_eng_len"},    64'(eng_len),    64'(0));
    chk({tagname, "_cmpl_valid"}, 64'(cmpl_valid), 64'(0));
    chk({tagname, "_cmpl_tag"},   64'(cmpl_tag),   64'(0));
    chk({tagname, "_cmpl_err"},   64'(cmpl_err),   64'(0));
    chk({tagname, "_busy"},       64'(busy),       64'(0));
    chk({tagname, "_fifo_count"}, 64'(fifo_count), 64'(0));
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [3:0]  tag;
    int          lat;
    int          exp_start;
    logic        exp_err;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit seen;
    // Expected start-high cycles are eng_lat + 1; a zero length never starts the engine.
    vecs[0] = '{src: 32'h0000_1000, dst: 32'h0000_2000, len: 16'd64,   tag: 4'd3,  lat: 10, exp_start: 11, exp_err: 1'b0};
    vecs[1] = '{src: 32'h0000_3000, dst: 32'h0000_4000, len: 16'd0,    tag: 4'd7,  lat: 5,  exp_start: 0,  exp_err: 1'b1};
    vecs[2] = '{src: 32'hDEAD_BEEF, dst: 32'h1234_5678, len: 16'd1,    tag: 4'd5,  lat: 0,  exp_start: 1,  exp_err: 1'b0};
    vecs[3] = '{src: 32'hFFFF_FFF0, dst: 32'h0000_0004, len: 16'hFFFF, tag: 4'd15, lat: 3,  exp_start: 4,  exp_err: 1'b0};

    rst = 1'b1; in_valid = 1'b0;
    in_src = '0; in_dst = '0; in_len = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      clear_mon();
      eng_lat = vecs[i].lat;
      push(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].tag);
      chk($sformatf("v%0d_start_after_accept", i), 64'(eng_start), 64'(0));
      chk($sformatf("v%0d_count_after_accept", i), 64'(fifo_count), 64'(1));
      chk($sformatf("v%0d_busy_after_accept", i), 64'(busy), 64'(1));
      @(negedge clk);
      chk($sformatf("v%0d_start_next", i), 64'(eng_start), 64'(vecs[i].exp_start != 0));
      chk($sformatf("v%0d_zlen_pulse", i), 64'(cmpl_valid), 64'(vecs[i].exp_err));
      wait_idle(200);
      chk($sformatf("v%0d_start_cycles", i), 64'(mon_start_cyc), 64'(vecs[i].exp_start));
      chk($sformatf("v%0d_cmpl_count", i), 64'(mon_cmpl), 64'(1));
      chk($sformatf("v%0d_cmpl_tag", i), 64'(cmpl_tag), 64'(vecs[i].tag));
      chk($sformatf("v%0d_cmpl_err", i), 64'(cmpl_err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_unstable", i), 64'(mon_unstable), 64'(0));
      if (vecs[i].exp_start != 0) begin
        chk($sformatf("v%0d_eng_src", i), 64'(cap_src), 64'(vecs[i].src));
        chk($sformatf("v%0d_eng_dst", i), 64'(cap_dst), 64'(vecs[i].dst));
        chk($sformatf("v%0d_eng_len", i), 64'(cap_len), 64'(vecs[i].len));
      end
      chk($sformatf("v%0d_busy_end", i), 64'(busy), 64'(0));
    end

    // Backpressure: stalled engine, five accepts, FIFO fills, sixth offer is ignored.
    clear_mon();
    eng_stall = 1'b1;
    for (int t = 0; t < 5; t++) push(32'h100 * t, 32'h8000 + t, 16'(4 * t + 4), 4'(t));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_count", 64'(fifo_count), 64'(4));
    in_src = 32'hBAD; in_dst = 32'hBAD; in_len = 16'd8; in_tag = 4'd5;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_ignored_count", 64'(fifo_count), 64'(4));
    chk("full_ignored_ready", 64'(in_ready), 64'(0));
    chk("full_stalled_start", 64'(eng_start), 64'(1));
    in_valid = 1'b0;
    eng_lat = 2;
    eng_stall = 1'b0;
    wait_idle(300);
    chk("drain_cmpl_count", 64'(mon_cmpl), 64'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < cmpl_q.size()) chk($sformatf("drain_order_%0d", k), 64'(cmpl_q[k]), 64'({1'b0, 4'(k)}));
    end

    // Reset with one descriptor in REQ and two queued.
    clear_mon();
    eng_stall = 1'b1;
    push(32'hA0, 32'hB0, 16'd16, 4'd1);
    push(32'hA1, 32'hB1, 16'd16, 4'd2);
    push(32'hA2, 32'hB2, 16'd16, 4'd3);
    chk("prerst_count", 64'(fifo_count), 64'(2));
    chk("prerst_start", 64'(eng_start), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    eng_stall = 1'b0;
    repeat (6) @(negedge clk);
    chk("postrst_cmpl_count", 64'(mon_cmpl), 64'(0));
    chk("postrst_start", 64'(eng_start), 64'(0));
    chk("postrst_count", 64'(fifo_count), 64'(0));

    // Simultaneous push and pop at fifo_count = 2.
    clear_mon();
    eng_stall = 1'b1;
    push(32'hC4, 32'hD4, 16'd4, 4'd4);
    push(32'hC5, 32'hD5, 16'd4, 4'd5);
    push(32'hC6, 32'hD6, 16'd4, 4'd6);
    chk("pp_count_before", 64'(fifo_count), 64'(2));
    eng_lat = 1;
    eng_stall = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmpl_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pp_first_cmpl_seen", 64'(seen), 64'(1));
    @(negedge clk);
    chk("pp_count_rel", 64'(fifo_count), 64'(2));
    in_src = 32'hC7; in_dst = 32'hD7; in_len = 16'd4; in_tag = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_count_same", 64'(fifo_count), 64'(2));
    chk("pp_start", 64'(eng_start), 64'(1));
    wait_idle(300);
    chk("pp_cmpl_count", 64'(mon_cmpl), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < cmpl_q.size()) chk($sformatf("pp_order_%0d", k), 64'(cmpl_q[k]), 64'({1'b0, 4'(k + 4)}));
    end

`ifdef DMA_SCHED_TIMEOUT_EN
    // Engine never answers: watchdog ends REQ after 16 cycles with an error completion.
    clear_mon();
    eng_stall = 1'b1;
    push(32'hE0, 32'hF0, 16'd32, 4'd9);
    wait_idle(100);
    chk("to_start_cycles", 64'(mon_start_cyc), 64'(16));
    chk("to_cmpl_count", 64'(mon_cmpl), 64'(1));
    chk("to_cmpl_tag", 64'(cmpl_tag), 64'(9));
    chk("to_cmpl_err", 64'(cmpl_err), 64'(1));
    clear_mon();
    eng_stall = 1'b0;
    eng_lat = 2;
    push(32'hE1, 32'hF1, 16'd32, 4'd10);
    wait_idle(100);
    chk("to_next_start_cycles", 64'(mon_start_cyc), 64'(3));
    chk("to_next_tag", 64'(cmpl_tag), 64'(10));
    chk("to_next_err", 64'(cmpl_err), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
